// File: rtl/mcontrol_if.sv
// rtl/mcontrol_if.sv - control/status bundle between mcontrol and the datav datapath
// The master drives every datapath control; the slave returns the instruction fields and zero flag.
interface mcontrol_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       memtoreg;
  logic       regdst;
  logic       iord;
  logic       pcen;
  logic       regwrite;
  logic [1:0] pcsrc;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord,
           pcen, regwrite, pcsrc, irwrite, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero,
    input  memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord,
           pcen, regwrite, pcsrc, irwrite, alucontrol, illegal
  );
endinterface

// File: rtl/mcontrol.sv
// rtl/mcontrol.sv - multicycle Moore control FSM for the 8-bit MIPS datav datapath
// Four byte fetches, decode, then per-opcode execute/writeback states.
module mcontrol (
  input  logic        clk,
  input  logic        reset,
  mcontrol_if.master  bus
);
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [4:0] {
    IDLE, FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR,
    RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
  } state_t;

  state_t     state_q, state_d;
  logic       pcwrite, branch, op_bad, funct_bad;
  logic [1:0] aluop;
  logic [2:0] funct_ctl;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    pcwrite          = 1'b0;
    branch           = 1'b0;
    aluop            = 2'b00;
    op_bad           = 1'b0;
    bus.memread      = 1'b0;
    bus.memwrite     = 1'b0;
    bus.alusrca      = 1'b0;
    bus.alusrcb      = 2'b00;
    bus.memtoreg     = 1'b0;
    bus.regdst       = 1'b0;
    bus.iord         = 1'b0;
    bus.regwrite     = 1'b0;
    bus.pcsrc        = 2'b00;
    bus.irwrite      = 4'b0000;
    case (state_q)
      IDLE:   state_d = FETCH1;
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        pcwrite     = 1'b1;
        case (state_q)
          FETCH1:  begin bus.irwrite = 4'b0001; state_d = FETCH2; end
          FETCH2:  begin bus.irwrite = 4'b0010; state_d = FETCH3; end
          FETCH3:  begin bus.irwrite = 4'b0100; state_d = FETCH4; end
          default: begin bus.irwrite = 4'b1000; state_d = DECODE; end
        endcase
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_R:         state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            op_bad  = 1'b1;
            state_d = FETCH1;
          end
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_LB) ? LBRD : SBWR;
      end
      LBRD:   begin bus.memread = 1'b1; bus.iord = 1'b1; state_d = LBWR; end
      LBWR:   begin bus.regwrite = 1'b1; bus.memtoreg = 1'b1; state_d = FETCH1; end
      SBWR:   begin bus.memwrite = 1'b1; bus.iord = 1'b1; state_d = FETCH1; end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b10;
        state_d     = RTYPEWR;
      end
      RTYPEWR: begin bus.regwrite = 1'b1; bus.regdst = 1'b1; state_d = FETCH1; end
      BEQEX: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        branch      = 1'b1;
        bus.pcsrc   = 2'b01;
        state_d     = FETCH1;
      end
      JEX:    begin pcwrite = 1'b1; bus.pcsrc = 2'b10; state_d = FETCH1; end
      ADDIEX: begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; state_d = ADDIWR; end
      ADDIWR: begin bus.regwrite = 1'b1; state_d = FETCH1; end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    funct_bad = 1'b0;
    case (bus.funct)
      6'b100000: funct_ctl = 3'b010;
      6'b100010: funct_ctl = 3'b110;
      6'b100100: funct_ctl = 3'b000;
      6'b100101: funct_ctl = 3'b001;
      6'b101010: funct_ctl = 3'b111;
      default: begin
        funct_ctl = 3'b010;
        funct_bad = 1'b1;
      end
    endcase
  end

  // IDLE keeps every output at zero, including the ALU add encoding used elsewhere
  always_comb begin
    if (state_q == IDLE) bus.alucontrol = 3'b000;
    else begin
      case (aluop)
        2'b01:   bus.alucontrol = 3'b110;
        2'b10:   bus.alucontrol = funct_ctl;
        default: bus.alucontrol = 3'b010;
      endcase
    end
  end

  assign bus.pcen    = pcwrite | (branch & bus.zero);
  assign bus.illegal = op_bad | ((state_q == RTYPEEX) & funct_bad);
endmodule

// File: tb/tb_mcontrol.sv
// tb/tb_mcontrol.sv - directed self-checking bench for mcontrol
// Outputs are packed into one vector; alucontrol is masked where the state leaves it unspecified.
module tb_mcontrol;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mcontrol_if bus ();
  mcontrol dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  wire [19:0] obs = {bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb, bus.memtoreg,
                     bus.regdst, bus.iord, bus.pcen, bus.regwrite, bus.pcsrc, bus.irwrite,
                     bus.alucontrol, bus.illegal};

  localparam logic [19:0] MALL  = 20'hFFFFF;
  localparam logic [19:0] MNOAC = 20'hFFFF1;

  function automatic logic [19:0] mk(input logic mr, input logic mw, input logic asa,
                                     input logic [1:0] asb, input logic mtr, input logic rd,
                                     input logic io, input logic pe, input logic rw,
                                     input logic [1:0] ps, input logic [3:0] ir,
                                     input logic [2:0] ac, input logic il);
    return {mr, mw, asa, asb, mtr, rd, io, pe, rw, ps, ir, ac, il};
  endfunction

  logic [19:0] F1, F2, F3, F4, DEC;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_decode();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op = 6'b000000; bus.funct = 6'b100000; bus.zero = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 20'h0) begin
      failures++;
      $display("FAIL reset_idle obs=%h exp=%h", obs, 20'h0);
    end
  endtask

  // Fetch sequence followed by an R-type add; FETCH1 returns 7 cycles later
  task automatic test_fetch_radd();
    logic [19:0] e [8];
    logic [19:0] m [8];
    e[0] = F1; e[1] = F2; e[2] = F3; e[3] = F4; e[4] = DEC;
    e[5] = mk(0,0,1,2'b00,0,0,0,0,0,2'b00,4'b0000,3'b010,0);
    e[6] = mk(0,0,0,2'b00,0,1,0,0,1,2'b00,4'b0000,3'b000,0);
    e[7] = F1;
    for (int i = 0; i < 8; i++) m[i] = MALL;
    m[6] = MNOAC;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ((obs & m[i]) !== (e[i] & m[i])) begin
        failures++;
        $display("FAIL fetch_radd[%0d] obs=%h exp=%h", i, obs & m[i], e[i] & m[i]);
      end
    end
  endtask

  task automatic test_rtype_funct();
    logic [5:0] fn [6];
    logic [2:0] ac [6];
    logic       il [6];
    fn[0] = 6'b100000; ac[0] = 3'b010; il[0] = 1'b0;
    fn[1] = 6'b100010; ac[1] = 3'b110; il[1] = 1'b0;
    fn[2] = 6'b100100; ac[2] = 3'b000; il[2] = 1'b0;
    fn[3] = 6'b100101; ac[3] = 3'b001; il[3] = 1'b0;
    fn[4] = 6'b101010; ac[4] = 3'b111; il[4] = 1'b0;
    fn[5] = 6'b111111; ac[5] = 3'b010; il[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.op = 6'b000000; bus.funct = fn[k];
      to_decode();
      tick();
      checks++;
      if (obs !== mk(0,0,1,2'b00,0,0,0,0,0,2'b00,4'b0000,ac[k],il[k])) begin
        failures++;
        $display("FAIL rtypeex_f%0d obs=%h exp=%h", k, obs,
                 mk(0,0,1,2'b00,0,0,0,0,0,2'b00,4'b0000,ac[k],il[k]));
      end
      tick();
      checks++;
      if ((obs & MNOAC) !== mk(0,0,0,2'b00,0,1,0,0,1,2'b00,4'b0000,3'b000,0)) begin
        failures++;
        $display("FAIL rtypewr_f%0d obs=%h exp=%h", k, obs & MNOAC,
                 mk(0,0,0,2'b00,0,1,0,0,1,2'b00,4'b0000,3'b000,0));
      end
      tick();
      checks++;
      if (obs !== F1) begin
        failures++;
        $display("FAIL rtype_ret_f%0d obs=%h exp=%h", k, obs, F1);
      end
    end
  endtask

  task automatic test_lb();
    logic [19:0] e [4];
    e[0] = mk(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b000,0);
    e[1] = mk(1,0,0,2'b00,0,0,1,0,0,2'b00,4'b0000,3'b000,0);
    e[2] = mk(0,0,0,2'b00,1,0,0,0,1,2'b00,4'b0000,3'b000,0);
    e[3] = F1 & MNOAC;
    bus.op = 6'b100000;
    to_decode();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ((obs & MNOAC) !== e[i]) begin
        failures++;
        $display("FAIL lb[%0d] obs=%h exp=%h", i, obs & MNOAC, e[i]);
      end
    end
  endtask

  task automatic test_sb();
    logic [19:0] e [3];
    e[0] = mk(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b000,0);
    e[1] = mk(0,1,0,2'b00,0,0,1,0,0,2'b00,4'b0000,3'b000,0);
    e[2] = F1 & MNOAC;
    bus.op = 6'b101000;
    to_decode();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ((obs & MNOAC) !== e[i]) begin
        failures++;
        $display("FAIL sb[%0d] obs=%h exp=%h", i, obs & MNOAC, e[i]);
      end
    end
  endtask

  task automatic test_beq();
    bus.op = 6'b000100; bus.zero = 1'b1;
    to_decode();
    tick();
    checks++;
    if (obs !== mk(0,0,1,2'b00,0,0,0,1,0,2'b01,4'b0000,3'b110,0)) begin
      failures++;
      $display("FAIL beq_taken obs=%h exp=%h", obs, mk(0,0,1,2'b00,0,0,0,1,0,2'b01,4'b0000,3'b110,0));
    end
    bus.zero = 1'b0;
    #1;
    checks++;
    if (obs !== mk(0,0,1,2'b00,0,0,0,0,0,2'b01,4'b0000,3'b110,0)) begin
      failures++;
      $display("FAIL beq_not_taken obs=%h exp=%h", obs, mk(0,0,1,2'b00,0,0,0,0,0,2'b01,4'b0000,3'b110,0));
    end
    tick();
    checks++;
    if (obs !== F1) begin
      failures++;
      $display("FAIL beq_ret obs=%h exp=%h", obs, F1);
    end
  endtask

  task automatic test_j_addi();
    bus.op = 6'b000010;
    to_decode();
    tick();
    checks++;
    if ((obs & MNOAC) !== mk(0,0,0,2'b00,0,0,0,1,0,2'b10,4'b0000,3'b000,0)) begin
      failures++;
      $display("FAIL jex obs=%h exp=%h", obs & MNOAC, mk(0,0,0,2'b00,0,0,0,1,0,2'b10,4'b0000,3'b000,0));
    end
    tick();
    bus.op = 6'b001000;
    to_decode();
    tick();
    checks++;
    if ((obs & MNOAC) !== mk(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b000,0)) begin
      failures++;
      $display("FAIL addiex obs=%h exp=%h", obs & MNOAC, mk(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b000,0));
    end
    tick();
    checks++;
    if ((obs & MNOAC) !== mk(0,0,0,2'b00,0,0,0,0,1,2'b00,4'b0000,3'b000,0)) begin
      failures++;
      $display("FAIL addiwr obs=%h exp=%h", obs & MNOAC, mk(0,0,0,2'b00,0,0,0,0,1,2'b00,4'b0000,3'b000,0));
    end
    tick();
    checks++;
    if (obs !== F1) begin
      failures++;
      $display("FAIL addi_ret obs=%h exp=%h", obs, F1);
    end
  endtask

  task automatic test_illegal();
    bus.op = 6'b111111;
    to_decode();
    checks++;
    if (obs !== (DEC | 20'h1)) begin
      failures++;
      $display("FAIL illegal_decode obs=%h exp=%h", obs, DEC | 20'h1);
    end
    tick();
    checks++;
    if (obs !== F1) begin
      failures++;
      $display("FAIL illegal_ret obs=%h exp=%h", obs, F1);
    end
  endtask

  task automatic test_reset_mid();
    bus.op = 6'b000000; bus.funct = 6'b100000;
    to_decode();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 20'h0) begin
        failures++;
        $display("FAIL reset_mid_idle[%0d] obs=%h exp=%h", i, obs, 20'h0);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== F1) begin
      failures++;
      $display("FAIL reset_mid_fetch obs=%h exp=%h", obs, F1);
    end
  endtask

  initial begin
    F1  = mk(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b0001,3'b010,0);
    F2  = mk(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b0010,3'b010,0);
    F3  = mk(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b0100,3'b010,0);
    F4  = mk(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b1000,3'b010,0);
    DEC = mk(0,0,0,2'b11,0,0,0,0,0,2'b00,4'b0000,3'b010,0);
    test_reset();
    test_fetch_radd();
    test_rtype_funct();
    test_lb();
    test_sb();
    test_beq();
    test_j_addi();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mcontrol.md
# mcontrol

Multicycle control unit for the 8-bit MIPS processor, sitting directly upstream of the `datav` datapath. It sequences the four byte-wide instruction fetches and the execute and writeback steps for lb, sb, R-type, beq, j and addi. Its outputs drive every `datav` control input, and it consumes the opcode, funct and `zero` that `datav` returns. It is a Moore FSM: the outputs decode from the state register, except `pcen` (uses `zero`) and `alucontrol` (uses `funct`).

## Interface
Parameters: none (encodings fixed below).
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; reset=0 at a rising edge forces state IDLE
- op  in  6  instr[31:26] from datav
- funct  in  6  instr[5:0] from datav
- zero  in  1  ALU zero flag from datav
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0=PC, 1=A register
- alusrcb  out  2  00=B, 01=const 1, 10=imm, 11=imm<<2
- memtoreg  out  1  1=register write data from MDR
- regdst  out  1  1=rd, 0=rt
- iord  out  1  1=address from ALUOut
- pcen  out  1  pcwrite | (branch & zero)
- regwrite  out  1  register file write enable
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- irwrite  out  4  one-hot instruction-byte load enable
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  unsupported opcode or funct flag

## Operation
- Opcodes:
  - lb=100000, sb=101000, R=000000, beq=000100, j=000010, addi=001000.
- R-type funct:
  - add=100000, sub=100010, and=100100, or=100101, slt=101010.
- Default value of every output in every state is 0; each state lists only the nonzero outputs.
- Internal aluop selects `alucontrol`:
  - aluop 00 → 010.
  - aluop 01 → 110.
  - aluop 10 → decoded from funct.
- States and transitions:
  - IDLE: outputs all 0 → FETCH1.
  - FETCH1..FETCH4: memread=1, alusrcb=01, pcwrite=1, aluop=00; irwrite=0001/0010/0100/1000 respectively. FETCHn → FETCHn+1; FETCH4 → DECODE.
  - DECODE: alusrcb=11, aluop=00 (branch target into ALUOut). Next state:
    - lb or sb → MEMADR
    - R → RTYPEEX
    - beq → BEQEX
    - j → JEX
    - addi → ADDIEX
    - any other opcode → FETCH1, with illegal=1 for this cycle.
  - MEMADR: alusrca=1, alusrcb=10 → LBRD (lb) or SBWR (sb).
  - LBRD: memread=1, iord=1 → LBWR.
  - LBWR: regwrite=1, memtoreg=1 → FETCH1.
  - SBWR: memwrite=1, iord=1 → FETCH1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWR.
  - RTYPEWR: regwrite=1, regdst=1 → FETCH1.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01 → FETCH1.
  - JEX: pcwrite=1, pcsrc=10 → FETCH1.
  - ADDIEX: alusrca=1, alusrcb=10 → ADDIWR.
  - ADDIWR: regwrite=1 → FETCH1.
- Unknown funct in RTYPEEX: alucontrol=010 and illegal=1. RTYPEWR still follows.
- op is sampled combinationally in DECODE and MEMADR. Datav holds instr stable from FETCH4 until the next FETCH1.

## Timing
- Reset:
  - Any edge with reset=0 puts the FSM in IDLE. All outputs read 0 in the following cycle.
  - Reset has priority over every transition. Asserting it mid-instruction aborts the instruction; no write strobe is issued after that edge.
- First edge with reset=1 moves IDLE → FETCH1.
- Cycles per instruction, FETCH1 through the last state:
  - lb 8
  - sb, R-type, addi 7
  - beq, j 6
- Outputs are valid for the whole state cycle. Datav registers act on the edge that ends the state.
- `pcen` in BEQEX follows `zero` combinationally within the same cycle.
- memread and memwrite are never both 1. Exactly one irwrite bit is set in FETCH1..4, and irwrite is 0000 in all other states.

## Test plan
- Reset and fetch: hold reset=0 for 2 edges, then release. Required response:
  - All outputs are 0 in IDLE.
  - The next four cycles show irwrite 0001, 0010, 0100, 1000, each with memread=1, alusrcb=01, pcen=1.
  - DECODE shows alusrcb=11.
- R-type add: op=000000, funct=100000. Required response:
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol=010.
  - RTYPEWR: regwrite=1, regdst=1.
  - Back in FETCH1 7 cycles after the previous FETCH1.
- lb and sb: op=100000. Required response:
  - MEMADR: alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - 8 cycles total.
  - Repeating with op=101000 gives memwrite=1 and iord=1 in SBWR, 7 cycles total.
- beq: op=000100. Required response in BEQEX:
  - With zero=1: pcen=1, pcsrc=01, alucontrol=110.
  - With zero=0: pcen=0.
- j and illegal: op=000010 gives pcen=1 and pcsrc=10 in JEX. op=111111 gives illegal=1 in DECODE, then FETCH1 on the next cycle.
- Reset mid-instruction: drive reset=0 during RTYPEEX. Required response: regwrite never asserts; IDLE, then FETCH1 after release.
